// File: rtl/piso_bitstream_feeder_if.sv
// Word-in / bit-out bundle between a word producer and the PISO feeder.
// The feeder side uses the slave modport; the producer side uses master.
interface piso_bitstream_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] par_in;
  logic             par_valid;
  logic             par_ready;
  logic             dout;
  logic             dout_valid;
  logic             sof;
  logic             busy;

  modport master (
    output par_in,
    output par_valid,
    input  par_ready,
    input  dout,
    input  dout_valid,
    input  sof,
    input  busy
  );

  modport slave (
    input  par_in,
    input  par_valid,
    output par_ready,
    output dout,
    output dout_valid,
    output sof,
    output busy
  );
endinterface

// File: rtl/piso_bitstream_feeder.sv
// Parallel-in serial-out feeder producing the detector's din bit stream.
// A one-word hold buffer lets consecutive words stream without gap bits.
module piso_bitstream_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  piso_bitstream_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic [WIDTH-1:0] hbuf, hbuf_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             hvalid, hvalid_next;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] sreg_shifted;

  assign bus.par_ready = !hvalid && !rst;
  assign accept        = bus.par_valid && bus.par_ready;
  assign last          = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign sreg_shifted  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

  // Outputs decode from registered state, so reset clears them asynchronously.
  assign bus.dout_valid = (state == SHIFT);
  assign bus.dout       = (state == SHIFT) && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign bus.sof        = (state == SHIFT) && (cnt == '0);
  assign bus.busy       = (state == SHIFT) || hvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      hbuf   <= '0;
      cnt    <= '0;
      hvalid <= 1'b0;
    end else begin
      state  <= state_next;
      sreg   <= sreg_next;
      hbuf   <= hbuf_next;
      cnt    <= cnt_next;
      hvalid <= hvalid_next;
    end
  end

  // On the final bit, the held word wins; otherwise a same-cycle accept loads directly.
  always_comb begin
    state_next  = state;
    sreg_next   = sreg;
    hbuf_next   = hbuf;
    cnt_next    = cnt;
    hvalid_next = hvalid;
    unique case (state)
      IDLE: begin
        if (accept) begin
          sreg_next  = bus.par_in;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          if (hvalid) begin
            sreg_next   = hbuf;
            hvalid_next = 1'b0;
            cnt_next    = '0;
          end else if (accept) begin
            sreg_next = bus.par_in;
            cnt_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          sreg_next = sreg_shifted;
          cnt_next  = cnt + 1'b1;
          if (accept) begin
            hbuf_next   = bus.par_in;
            hvalid_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_piso_bitstream_feeder.sv
// Drives MSB-first and LSB-first feeders with one shared word stream and
// compares every output against a queue-of-pending-bits model each cycle.
module tb_piso_bitstream_feeder;
  localparam int W = 8;

  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  logic         stim_valid = 1'b0;
  logic [W-1:0] stim_data  = '0;
  logic         last_accept = 1'b0;
  int           total = 0;
  int           bad   = 0;
  logic [31:0]  cap_m = '0;
  logic [31:0]  cap_l = '0;
  logic [1:0]   q_m[$];
  logic [1:0]   q_l[$];

  always #5 clk = ~clk;

  piso_bitstream_feeder_if #(.WIDTH(W)) bus_m ();
  piso_bitstream_feeder_if #(.WIDTH(W)) bus_l ();

  assign bus_m.par_in    = stim_data;
  assign bus_m.par_valid = stim_valid;
  assign bus_l.par_in    = stim_data;
  assign bus_l.par_valid = stim_valid;

  piso_bitstream_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  piso_bitstream_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  // The feeder holds at most the word on the wire plus one buffered word.
  function automatic logic model_ready();
    return (q_m.size() <= W) && !rst;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic vm, vl;
    vm = (q_m.size() > 0);
    vl = (q_l.size() > 0);
    checkOutput({tag, "/m_valid"}, 32'(bus_m.dout_valid), 32'(vm));
    checkOutput({tag, "/m_dout"},  32'(bus_m.dout),       32'(vm ? q_m[0][0] : 1'b0));
    checkOutput({tag, "/m_sof"},   32'(bus_m.sof),        32'(vm ? q_m[0][1] : 1'b0));
    checkOutput({tag, "/m_busy"},  32'(bus_m.busy),       32'(vm));
    checkOutput({tag, "/m_ready"}, 32'(bus_m.par_ready),  32'(model_ready()));
    checkOutput({tag, "/l_valid"}, 32'(bus_l.dout_valid), 32'(vl));
    checkOutput({tag, "/l_dout"},  32'(bus_l.dout),       32'(vl ? q_l[0][0] : 1'b0));
    checkOutput({tag, "/l_sof"},   32'(bus_l.sof),        32'(vl ? q_l[0][1] : 1'b0));
    checkOutput({tag, "/l_busy"},  32'(bus_l.busy),       32'(vl));
    checkOutput({tag, "/l_ready"}, 32'(bus_l.par_ready),  32'(model_ready()));
  endtask

  // One clock: the bit on the wire is consumed, an accepted word queues its bits.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input string tag);
    logic acc;
    stim_valid = v;
    stim_data  = d;
    acc = v && model_ready();
    @(posedge clk);
    if (q_m.size() > 0) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
    end
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        q_m.push_back({i == 0, d[W-1-i]});
        q_l.push_back({i == 0, d[i]});
      end
    end
    last_accept = acc;
    #1;
    checkAll(tag);
    if (bus_m.dout_valid) cap_m = {cap_m[30:0], bus_m.dout};
    if (bus_l.dout_valid) cap_l = {bus_l.dout, cap_l[31:1]};
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) applyStimulus(1'b0, '0, tag);
  endtask

  task automatic sendWord(input logic [W-1:0] d, input logic scramble, input string tag);
    int n;
    n = 0;
    last_accept = 1'b0;
    while (!last_accept && n < 3 * W) begin
      if (scramble && !model_ready()) applyStimulus(1'b1, W'($urandom), tag);
      else applyStimulus(1'b1, d, tag);
      n++;
    end
    if (!last_accept) checkOutput({tag, "/timeout"}, 32'd0, 32'd1);
  endtask

  task automatic doReset(input string tag);
    stim_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    q_m.delete();
    q_l.delete();
    checkAll({tag, "/async"});
    repeat (2) begin
      @(posedge clk);
      #1;
      checkAll({tag, "/held"});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAll({tag, "/release"});
  endtask

  initial begin
    logic [W-1:0] cur;
    logic         v;
    $display("[TB] start");
    #1;
    checkAll("por");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAll("por_release");

    applyStimulus(1'b1, 8'hB6, "b6");
    idle(W, "b6");
    checkOutput("b6_bits_m", {24'b0, cap_m[7:0]},   32'hB6);
    checkOutput("b6_bits_l", {24'b0, cap_l[31:24]}, 32'hB6);

    applyStimulus(1'b1, 8'h0D, "0d");
    idle(W, "0d");
    checkOutput("0d_bits_l", {24'b0, cap_l[31:24]}, 32'h0D);
    checkOutput("0d_bits_m", {24'b0, cap_m[7:0]},   32'h0D);

    sendWord(8'hB6, 1'b0, "b2b");
    sendWord(8'h2D, 1'b0, "b2b");
    idle(2 * W, "b2b");
    checkOutput("b2b_bits_m", {16'b0, cap_m[15:0]},  32'hB62D);
    checkOutput("b2b_bits_l", {16'b0, cap_l[31:16]}, 32'h2DB6);

    applyStimulus(1'b1, 8'h5A, "direct");
    idle(W - 1, "direct");
    applyStimulus(1'b1, 8'h0B, "direct");
    checkOutput("direct_sof", 32'(bus_m.sof), 32'd1);
    idle(W + 1, "direct");
    checkOutput("direct_bits_m", {16'b0, cap_m[15:0]}, 32'h5A0B);

    sendWord(8'hA1, 1'b0, "bp");
    sendWord(8'hC3, 1'b0, "bp");
    sendWord(8'h3C, 1'b1, "bp");
    idle(3 * W, "bp");
    checkOutput("bp_bits_m", {8'b0, cap_m[23:0]}, 32'hA1C33C);

    sendWord(8'hE7, 1'b0, "midrst");
    idle(3, "midrst");
    doReset("midrst");
    idle(2, "midrst_after");

    cur = W'($urandom);
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(v, cur, "rand");
      if (last_accept) cur = W'($urandom);
      if (i == 200) doReset("rand_rst");
    end
    idle(2 * W + 2, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
